// File: rtl/core_l1d_req_ctrl.sv
// Memory-stage L1D transaction sequencer: one outstanding request, valid/ack handshake,
// response wait, pipeline stall, kill-drop and a sticky wait-time watchdog.
module core_l1d_req_ctrl #(
    parameter int unsigned TO_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_val_in,
    input  logic [2:0]  req_cop_in,
    input  logic [2:0]  req_size_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    input  logic        kill_in,
    output logic        l1d_req_val_out,
    output logic [2:0]  l1d_req_cop_out,
    output logic [2:0]  l1d_req_size_out,
    output logic [31:0] l1d_req_addr_out,
    output logic [31:0] l1d_req_wdata_out,
    input  logic        l1d_req_ack_in,
    input  logic        l1d_resp_val_in,
    input  logic [31:0] l1d_resp_data_in,
    output logic        stall_out,
    output logic [31:0] ld_data_out,
    output logic        ld_data_val_out,
    output logic        timeout_err_out
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    localparam logic [TO_W-1:0] WdMax     = {TO_W{1'b1}};
    localparam logic [TO_W-1:0] WdPenult  = WdMax - TO_W'(1);

    state_e          state_q;
    logic [TO_W-1:0] wd_cnt_q;
    logic            drop_q;
    logic            accept;
    logic            lat_is_ld;
    logic            drop_now;

    assign accept    = req_val_in & ~kill_in &
                       ((req_cop_in[1:0] == 2'b01) | (req_cop_in[1:0] == 2'b10));
    assign lat_is_ld = (l1d_req_cop_out[1:0] == 2'b01);
    // A kill landing in the completing cycle still suppresses delivery.
    assign drop_now  = drop_q | kill_in;

    assign stall_out = (state_q != StIdle) | accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            wd_cnt_q          <= '0;
            drop_q            <= 1'b0;
            l1d_req_val_out   <= 1'b0;
            l1d_req_cop_out   <= '0;
            l1d_req_size_out  <= '0;
            l1d_req_addr_out  <= '0;
            l1d_req_wdata_out <= '0;
            ld_data_out       <= '0;
            ld_data_val_out   <= 1'b0;
            timeout_err_out   <= 1'b0;
        end else begin
            ld_data_val_out <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q           <= StReq;
                        wd_cnt_q          <= '0;
                        l1d_req_val_out   <= 1'b1;
                        l1d_req_cop_out   <= req_cop_in;
                        l1d_req_size_out  <= req_size_in;
                        l1d_req_addr_out  <= req_addr_in;
                        l1d_req_wdata_out <= req_wdata_in;
                    end
                end
                StReq: begin
                    if (l1d_req_ack_in && (!lat_is_ld || l1d_resp_val_in)) begin
                        state_q         <= StIdle;
                        wd_cnt_q        <= '0;
                        drop_q          <= 1'b0;
                        l1d_req_val_out <= 1'b0;
                        if (lat_is_ld && !drop_now) begin
                            ld_data_out     <= l1d_resp_data_in;
                            ld_data_val_out <= 1'b1;
                        end
                    end else if (l1d_req_ack_in) begin
                        state_q         <= StResp;
                        wd_cnt_q        <= '0;
                        drop_q          <= drop_now;
                        l1d_req_val_out <= 1'b0;
                    end else begin
                        drop_q <= drop_now;
                        if (wd_cnt_q != WdMax) begin
                            wd_cnt_q <= wd_cnt_q + TO_W'(1);
                            if (wd_cnt_q == WdPenult) timeout_err_out <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    if (l1d_resp_val_in) begin
                        state_q  <= StIdle;
                        wd_cnt_q <= '0;
                        drop_q   <= 1'b0;
                        if (!drop_now) begin
                            ld_data_out     <= l1d_resp_data_in;
                            ld_data_val_out <= 1'b1;
                        end
                    end else begin
                        drop_q <= drop_now;
                        if (wd_cnt_q != WdMax) begin
                            wd_cnt_q <= wd_cnt_q + TO_W'(1);
                            if (wd_cnt_q == WdPenult) timeout_err_out <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_core_l1d_req_ctrl.sv
// Randomized bench for core_l1d_req_ctrl against a transaction-level reference model.
module tb_core_l1d_req_ctrl;

    localparam int TO_W = 4;
    localparam int WMAX = (1 << TO_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_val_in = 1'b0;
    logic [2:0]  req_cop_in = '0;
    logic [2:0]  req_size_in = '0;
    logic [31:0] req_addr_in = '0;
    logic [31:0] req_wdata_in = '0;
    logic        kill_in = 1'b0;
    logic        l1d_req_val_out;
    logic [2:0]  l1d_req_cop_out;
    logic [2:0]  l1d_req_size_out;
    logic [31:0] l1d_req_addr_out;
    logic [31:0] l1d_req_wdata_out;
    logic        l1d_req_ack_in = 1'b0;
    logic        l1d_resp_val_in = 1'b0;
    logic [31:0] l1d_resp_data_in = '0;
    logic        stall_out;
    logic [31:0] ld_data_out;
    logic        ld_data_val_out;
    logic        timeout_err_out;

    core_l1d_req_ctrl #(.TO_W(TO_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_val_in        (req_val_in),
        .req_cop_in        (req_cop_in),
        .req_size_in       (req_size_in),
        .req_addr_in       (req_addr_in),
        .req_wdata_in      (req_wdata_in),
        .kill_in           (kill_in),
        .l1d_req_val_out   (l1d_req_val_out),
        .l1d_req_cop_out   (l1d_req_cop_out),
        .l1d_req_size_out  (l1d_req_size_out),
        .l1d_req_addr_out  (l1d_req_addr_out),
        .l1d_req_wdata_out (l1d_req_wdata_out),
        .l1d_req_ack_in    (l1d_req_ack_in),
        .l1d_resp_val_in   (l1d_resp_val_in),
        .l1d_resp_data_in  (l1d_resp_data_in),
        .stall_out         (stall_out),
        .ld_data_out       (ld_data_out),
        .ld_data_val_out   (ld_data_val_out),
        .timeout_err_out   (timeout_err_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a transaction is either absent, awaiting ack, or acked and awaiting data.
    bit          m_busy, m_acked, m_drop, m_to, m_ld_val, m_new;
    logic [2:0]  m_cop, m_size;
    logic [31:0] m_addr, m_wdata, m_ld_data;
    int          m_wait;
    int          hold;

    task automatic model_reset();
        m_busy = 0; m_acked = 0; m_drop = 0; m_to = 0; m_ld_val = 0; m_new = 0;
        m_cop = '0; m_size = '0; m_addr = '0; m_wdata = '0; m_ld_data = '0;
        m_wait = 0;
    endtask

    function automatic bit wants_access();
        return req_val_in && !kill_in &&
               (req_cop_in[1:0] == 2'b01 || req_cop_in[1:0] == 2'b10);
    endfunction

    task automatic check_all(input string ph);
        check_eq({ph, "_val"},   32'(l1d_req_val_out),  32'(m_busy && !m_acked));
        check_eq({ph, "_cop"},   32'(l1d_req_cop_out),  32'(m_cop));
        check_eq({ph, "_size"},  32'(l1d_req_size_out), 32'(m_size));
        check_eq({ph, "_addr"},  l1d_req_addr_out,      m_addr);
        check_eq({ph, "_wdata"}, l1d_req_wdata_out,     m_wdata);
        check_eq({ph, "_stall"}, 32'(stall_out),        32'(m_busy || wants_access()));
        check_eq({ph, "_ldata"}, ld_data_out,           m_ld_data);
        check_eq({ph, "_ldval"}, 32'(ld_data_val_out),  32'(m_ld_val));
        check_eq({ph, "_tmo"},   32'(timeout_err_out),  32'(m_to));
    endtask

    task automatic model_step();
        bit done, deliver, moved, is_ld;
        m_ld_val = 0;
        m_new = 0;
        if (!m_busy) begin
            if (wants_access()) begin
                m_busy = 1; m_acked = 0; m_wait = 0; m_new = 1;
                m_cop = req_cop_in; m_size = req_size_in;
                m_addr = req_addr_in; m_wdata = req_wdata_in;
            end
            return;
        end
        is_ld = (m_cop[1:0] == 2'b01);
        m_drop = m_drop || kill_in;
        done = 0; deliver = 0; moved = 0;
        if (!m_acked) begin
            if (l1d_req_ack_in) begin
                if (!is_ld) done = 1;
                else if (l1d_resp_val_in) begin done = 1; deliver = 1; end
                else begin m_acked = 1; moved = 1; end
            end
        end else if (l1d_resp_val_in) begin
            done = 1; deliver = 1;
        end
        if (done) begin
            if (deliver && !m_drop) begin
                m_ld_data = l1d_resp_data_in;
                m_ld_val = 1;
            end
            m_busy = 0; m_acked = 0; m_drop = 0; m_wait = 0;
        end else if (moved) begin
            m_wait = 0;
        end else begin
            if (m_wait < WMAX) m_wait++;
            if (m_wait == WMAX) m_to = 1;
        end
    endtask

    initial begin
        model_reset();
        hold = 0;
        #2 rst_n = 1'b0;
        #1 check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            req_val_in   = ($urandom_range(0, 3) != 0);
            req_cop_in   = 3'($urandom);
            req_size_in  = 3'($urandom);
            req_addr_in  = $urandom;
            req_wdata_in = $urandom;
            kill_in      = ($urandom_range(0, 9) == 0);
            l1d_resp_data_in = $urandom;
            if (hold > 0) begin
                hold--;
                l1d_req_ack_in  = 1'b0;
                l1d_resp_val_in = 1'b0;
            end else begin
                l1d_req_ack_in  = ($urandom_range(0, 2) == 0);
                l1d_resp_val_in = ($urandom_range(0, 2) == 0);
            end
            #1 check_all("cyc");
            if ($urandom_range(0, 149) == 0) begin
                req_val_in = 1'b0;
                #1 rst_n = 1'b0;
                model_reset();
                hold = 0;
                #1 check_all("arst");
                #1 rst_n = 1'b1;
            end
            @(posedge clk);
            model_step();
            if (m_new && $urandom_range(0, 7) == 0) hold = $urandom_range(10, 30);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
